operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Read side of the write-back register file. Accepts decoded instructions (rs1, rs2, rd).
//  Reads both source operands from the 32 architectural registers produced by Write_Back,
//  bypasses a same-cycle write-back, and stalls on read-after-write hazards via a scoreboard.
//  Presents operands to execute through a registered valid/ready stage.
// PARAMETERS
//  DW     32  data width of a register
//  AW     5   register index width
//  NREGS  32  number of architectural registers (2**AW)
//  CNT_W  16  width of the stall-cycle performance counter
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-high reset
//  req_valid    in   1         decoded instruction available
//  req_ready    out  1         instruction accepted this cycle when req_valid & req_ready
//  req_rs1      in   AW        source register 1 index
//  req_rs2      in   AW        source register 2 index
//  req_rd       in   AW        destination register index
//  req_rd_we    in   1         instruction will write req_rd
//  rf_bus       in   NREGS*DW  register file contents; Rn at [n*DW +: DW]
//  wb_valid     in   1         write-back commits this cycle
//  wb_dest_reg  in   AW        write-back destination index
//  wb_value     in   DW        write-back data; visible on rf_bus from the next cycle
//  op_valid     out  1         operand bundle valid
//  op_ready     in   1         execute consumes bundle when op_valid & op_ready
//  op_a         out  DW        value of rs1
//  op_b         out  DW        value of rs2
//  op_rd        out  AW        forwarded destination index
//  op_rd_we     out  1         forwarded write enable
//  stall_cnt    out  CNT_W     count of cycles with req_valid & !req_ready, saturating
// BEHAVIOUR
//  Reset (sync, high): op_valid=0, op_a=op_b=0, op_rd=0, op_rd_we=0, scoreboard=0, stall_cnt=0.
//  Register 0 (%g0): always reads 0; never marked pending; rd=0 writes do not set the scoreboard.
//  Scoreboard: pending[NREGS]. On accept with rd_we & rd!=0, set pending[rd].
//   A write-back with wb_valid clears pending[wb_dest_reg]. Set and clear of the same index in one
//   cycle: set wins.
//  Hazard: (rs1!=0 & pending[rs1] & !(wb_valid & wb_dest_reg==rs1)), same test for rs2.
//  Output stage states: EMPTY (op_valid=0), FULL (op_valid=1).
//   EMPTY->FULL on accept. FULL->EMPTY on consume without accept.
//   FULL->FULL on consume+accept, or when held (no consume).
//  req_ready = !hazard & (state==EMPTY | op_ready). Combinational; no dependence on req_valid.
//  Operand select, per source: rs==0 -> 0. Else wb_valid & wb_dest_reg==rs -> wb_value (bypass).
//   Else the rf_bus slice.
//  Latency: accept in cycle N -> op_valid and operands registered at edge N+1.
//  While FULL & !op_ready: op_a, op_b, op_rd and op_rd_we hold stable. No re-read of rf_bus.
//  stall_cnt increments on req_valid & !req_ready. Holds at 2**CNT_W-1.
//  Reset mid-operation: the bundle in flight is dropped and all pending bits are cleared.
// STRUCTURE
//  sparc_pkg: DW, AW, NREGS, REG_G0=0, function reg_slice(bus, idx).
//  Sub-module reg_scoreboard: set/clear ports, set-wins rule, hazard outputs for two read
//   indices with wb bypass masking.
//  Top level: operand muxes, output register FSM, stall counter.
// TESTING
//  1 Reset, then rf_bus R3=400, R4=500. Issue rs1=3, rs2=4, rd=5 -> next cycle op_a=400,
//    op_b=500, op_rd=5.
//  2 Issue rd=6 (we=1), then rs1=6 -> req_ready=0 and stall_cnt increments.
//    wb_valid with dest=6, value=700 -> accepted that cycle, op_a=700 (bypass).
//  3 rs1=0, rs2=0 with R0 on rf_bus=100 -> op_a=op_b=0. Issue rd=0 we=1, then rs1=0 -> no stall.
//  4 op_ready=0 for 3 cycles -> bundle held stable, req_ready=0.
//    op_ready=1 with a new req -> back-to-back accept, no bubble.
//  5 Same cycle: wb clears R7 and new issue sets rd=7 -> pending[7]=1, next rs1=7 stalls.
//  6 Assert reset while FULL with pending R9 -> op_valid=0.
//    rs1=9 is then accepted immediately. stall_cnt=0.

Source files
------------

// File: rtl/sparc_pkg.sv
// Shared constants, output-stage state type and register-file slicing helper
// for the operand fetch stage.
package sparc_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    localparam logic [AW-1:0] REG_G0 = 5'd0;

    typedef enum logic [0:0] {
        OS_EMPTY = 1'b0,
        OS_FULL  = 1'b1
    } ostate_e;

    function automatic logic [DW-1:0] reg_slice(input logic [NREGS*DW-1:0] bus,
                                                input logic [AW-1:0]       idx);
        return bus[idx*DW +: DW];
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue,
// cleared by write-back, with hazard lookups for two source indices.
module reg_scoreboard
    import sparc_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          set_valid_i,
    input  logic [AW-1:0] set_idx_i,
    input  logic          clr_valid_i,
    input  logic [AW-1:0] clr_idx_i,
    input  logic [AW-1:0] rd_idx_a_i,
    input  logic [AW-1:0] rd_idx_b_i,
    output logic          hazard_a_o,
    output logic          hazard_b_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Next pending vector; a set on the same index as a clear takes priority.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NREGS; i++) begin
            if (set_valid_i && (set_idx_i == i[AW-1:0]) && (i != 0)) begin
                pending_d[i] = 1'b1;
            end else if (clr_valid_i && (clr_idx_i == i[AW-1:0])) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // Pending bit storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A write-back landing this cycle resolves the hazard because it is bypassed.
    always_comb begin
        hazard_a_o = (rd_idx_a_i != REG_G0) && pending_q[rd_idx_a_i]
                     && !(clr_valid_i && (clr_idx_i == rd_idx_a_i));
        hazard_b_o = (rd_idx_b_i != REG_G0) && pending_q[rd_idx_b_i]
                     && !(clr_valid_i && (clr_idx_i == rd_idx_b_i));
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads two sources from the register file with write-back bypass,
// stalls on pending destinations and hands a registered bundle to execute.
module operand_fetch
    import sparc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_rs1,
    input  logic [AW-1:0]       req_rs2,
    input  logic [AW-1:0]       req_rd,
    input  logic                req_rd_we,
    input  logic [NREGS*DW-1:0] rf_bus,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_dest_reg,
    input  logic [DW-1:0]       wb_value,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [DW-1:0]       op_a,
    output logic [DW-1:0]       op_b,
    output logic [AW-1:0]       op_rd,
    output logic                op_rd_we,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ostate_e          state_q, state_d;
    logic [DW-1:0]    op_a_q, op_a_d;
    logic [DW-1:0]    op_b_q, op_b_d;
    logic [AW-1:0]    op_rd_q, op_rd_d;
    logic             op_rd_we_q, op_rd_we_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic          hazard_a_s, hazard_b_s;
    logic          req_ready_s;
    logic          accept_s;
    logic [DW-1:0] src_a_s, src_b_s;

    reg_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_valid_i (accept_s && req_rd_we && (req_rd != REG_G0)),
        .set_idx_i   (req_rd),
        .clr_valid_i (wb_valid),
        .clr_idx_i   (wb_dest_reg),
        .rd_idx_a_i  (req_rs1),
        .rd_idx_b_i  (req_rs2),
        .hazard_a_o  (hazard_a_s),
        .hazard_b_o  (hazard_b_s)
    );

    // Handshake: room exists when empty or when the held bundle leaves this cycle.
    always_comb begin
        req_ready_s = !(hazard_a_s || hazard_b_s)
                      && ((state_q == OS_EMPTY) || op_ready);
        accept_s    = req_valid && req_ready_s;
    end

    // Source operand muxes: %g0, then write-back bypass, then register file.
    always_comb begin
        if (req_rs1 == REG_G0) begin
            src_a_s = '0;
        end else if (wb_valid && (wb_dest_reg == req_rs1)) begin
            src_a_s = wb_value;
        end else begin
            src_a_s = reg_slice(rf_bus, req_rs1);
        end
        if (req_rs2 == REG_G0) begin
            src_b_s = '0;
        end else if (wb_valid && (wb_dest_reg == req_rs2)) begin
            src_b_s = wb_value;
        end else begin
            src_b_s = reg_slice(rf_bus, req_rs2);
        end
    end

    // Output stage next state and bundle capture; the bundle only changes on accept.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_rd_d    = op_rd_q;
        op_rd_we_d = op_rd_we_q;
        case (state_q)
            OS_EMPTY: begin
                if (accept_s) begin
                    state_d = OS_FULL;
                end else begin
                    state_d = OS_EMPTY;
                end
            end
            OS_FULL: begin
                if (op_ready && !accept_s) begin
                    state_d = OS_EMPTY;
                end else begin
                    state_d = OS_FULL;
                end
            end
            default: begin
                state_d = OS_EMPTY;
            end
        endcase
        if (accept_s) begin
            op_a_d     = src_a_s;
            op_b_d     = src_b_s;
            op_rd_d    = req_rd;
            op_rd_we_d = req_rd_we;
        end else begin
            op_a_d     = op_a_q;
            op_b_d     = op_b_q;
            op_rd_d    = op_rd_q;
            op_rd_we_d = op_rd_we_q;
        end
    end

    // Saturating count of cycles a presented request was refused.
    always_comb begin
        if (req_valid && !req_ready_s && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_ONE;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, bundle and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= OS_EMPTY;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_rd_q    <= '0;
            op_rd_we_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_rd_q    <= op_rd_d;
            op_rd_we_q <= op_rd_we_d;
            stall_q    <= stall_d;
        end
    end

    assign req_ready = req_ready_s;
    assign op_valid  = (state_q == OS_FULL);
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_rd     = op_rd_q;
    assign op_rd_we  = op_rd_we_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scenario-driven bench for operand_fetch: expected bundles are queued when a
// request should be accepted and compared when execute consumes them.
module tb_operand_fetch;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_rs1, req_rs2, req_rd;
    logic          req_rd_we;
    logic [1023:0] rf_bus;
    logic          wb_valid;
    logic [4:0]    wb_dest_reg;
    logic [31:0]   wb_value;
    logic          op_valid;
    logic          op_ready;
    logic [31:0]   op_a, op_b;
    logic [4:0]    op_rd;
    logic          op_rd_we;
    logic [15:0]   stall_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rf[32];
    logic [15:0] exp_stall;
    int          n_cmp = 0;
    int          n_err = 0;

    operand_fetch #(.CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .req_rd_we   (req_rd_we),
        .rf_bus      (rf_bus),
        .wb_valid    (wb_valid),
        .wb_dest_reg (wb_dest_reg),
        .wb_value    (wb_value),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_rd       (op_rd),
        .op_rd_we    (op_rd_we),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive_rf();
        for (int i = 0; i < 32; i++) begin
            rf_bus[i*32 +: 32] = rf[i];
        end
    endtask

    function automatic logic [31:0] model_src(input logic [4:0] rs, input logic wbv,
                                              input logic [4:0] wbd, input logic [31:0] wbval);
        if (rs == 5'd0) return 32'd0;
        if (wbv && (wbd == rs)) return wbval;
        return rf[rs];
    endfunction

    // One clock cycle: drive, check at the falling edge, advance past the rising edge.
    task automatic cyc(input string name, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic we,
                       input logic wbv, input logic [4:0] wbd, input logic [31:0] wbval,
                       input logic opr, input logic exp_rdy);
        exp_t e;
        req_valid = v;   req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_rd_we = we;
        wb_valid = wbv;  wb_dest_reg = wbd; wb_value = wbval; op_ready = opr;
        drive_rf();
        @(negedge clk);
        n_cmp++;
        if (op_valid !== (exp_q.size() != 0)) begin
            n_err++;
            $display("FAIL %s op_valid: got %0b want %0b", name, op_valid, exp_q.size() != 0);
        end
        n_cmp++;
        if (stall_cnt !== exp_stall) begin
            n_err++;
            $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, exp_stall);
        end
        if (v) begin
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL %s req_ready: got %0b want %0b", name, req_ready, exp_rdy);
            end
        end
        if (exp_q.size() != 0) begin
            e = opr ? exp_q.pop_front() : exp_q[0];
            n_cmp++;
            if ({op_a, op_b, op_rd, op_rd_we} !== {e.a, e.b, e.rd, e.we}) begin
                n_err++;
                $display("FAIL %s bundle: got a=%0d b=%0d rd=%0d we=%0b want a=%0d b=%0d rd=%0d we=%0b",
                         name, op_a, op_b, op_rd, op_rd_we, e.a, e.b, e.rd, e.we);
            end
        end
        if (v && exp_rdy) begin
            e.a  = model_src(rs1, wbv, wbd, wbval);
            e.b  = model_src(rs2, wbv, wbd, wbval);
            e.rd = rd;
            e.we = we;
            exp_q.push_back(e);
        end
        if (v && !exp_rdy && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
        @(posedge clk);
        #1;
        if (wbv && (wbd != 5'd0)) rf[wbd] = wbval;
    endtask

    task automatic idle(input string name, input logic opr);
        cyc(name, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, opr, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b0;
        req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd0; req_rd_we = 1'b0;
        wb_dest_reg = 5'd0; wb_value = 32'd0;
        drive_rf();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        exp_q.delete();
        exp_stall = 16'd0;
        n_cmp++;
        if ({op_valid, op_a, op_b, op_rd, op_rd_we, stall_cnt} !== 87'd0) begin
            n_err++;
            $display("FAIL reset: got valid=%0b a=%0d b=%0d rd=%0d we=%0b stall=%0d want all 0",
                     op_valid, op_a, op_b, op_rd, op_rd_we, stall_cnt);
        end
    endtask

    task automatic test_basic_read();
        rf[3] = 32'd400;
        rf[4] = 32'd500;
        cyc("basic", 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cyc("basic_clr5", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5, 32'd55, 1'b1, 1'b0);
        idle("basic_drain", 1'b1);
    endtask

    task automatic test_raw_stall_bypass();
        cyc("raw_set6", 1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cyc("raw_stall", 1'b1, 5'd6, 5'd0, 5'd8, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cyc("raw_stall2", 1'b1, 5'd0, 5'd6, 5'd8, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cyc("raw_bypass", 1'b1, 5'd6, 5'd0, 5'd8, 1'b0, 1'b1, 5'd6, 32'd700, 1'b1, 1'b1);
        idle("raw_drain", 1'b1);
    endtask

    task automatic test_g0();
        rf[0] = 32'd100;
        cyc("g0_read", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cyc("g0_nostall", 1'b1, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        idle("g0_drain", 1'b1);
    endtask

    task automatic test_back_to_back();
        cyc("hold_load", 1'b1, 5'd3, 5'd4, 5'd10, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        rf[3] = 32'd999;
        for (int i = 0; i < 3; i++) begin
            cyc("hold", 1'b1, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        end
        cyc("b2b_1", 1'b1, 5'd4, 5'd3, 5'd12, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cyc("b2b_2", 1'b1, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cyc("b2b_clr12", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd12, 32'd1200, 1'b1, 1'b0);
        idle("b2b_drain", 1'b1);
    endtask

    task automatic test_set_wins();
        cyc("sw_set7", 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        cyc("sw_setclr", 1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 5'd7, 32'd77, 1'b1, 1'b1);
        cyc("sw_rs1", 1'b1, 5'd7, 5'd2, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cyc("sw_rs2", 1'b1, 5'd2, 5'd7, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        cyc("sw_clr7", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7, 32'd88, 1'b1, 1'b0);
        cyc("sw_after", 1'b1, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        idle("sw_drain", 1'b1);
    endtask

    task automatic test_reset_mid();
        cyc("rm_set9", 1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        test_reset();
        cyc("rm_rs9", 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
        idle("rm_drain", 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd1000 + i;
        rf[0] = 32'd0;
        rf_bus = '0;
        exp_stall = 16'd0;
        test_reset();
        test_basic_read();
        test_raw_stall_bypass();
        test_g0();
        test_back_to_back();
        test_set_wins();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
